// File: rtl/serial_lsu_if.sv
// serial_lsu_if: bundles the serial core-side signals and the word-wide
// memory-side signals of the serial load/store unit.
//
// Parameters: XLEN (32/64), ADDR_W (retained byte-address bits),
//             DIGIT (bits per serial cycle: 1, 2, 4 or 8).
//
// Signals (direction as seen by the LSU, i.e. the slave modport):
//   start, store, func[2:0]   in   transaction request, sampled in IDLE
//   ser_in[DIGIT]             in   address / store-data digits, LSB first
//   ser_out[DIGIT], ser_valid out  load-result digits, LSB first
//   busy, done, err           out  status; err is meaningful only with done
//   mem_addr, mem_req, mem_we, mem_be, mem_wdata   out  word-wide memory port
//   mem_rdata, mem_ack        in   memory response
//
// Memory handshake: mem_req rises when the access is presented and stays high,
// with mem_addr/mem_we/mem_be/mem_wdata held stable, until the memory returns
// mem_ack in a cycle where mem_req is high. That ack cycle completes the
// transfer (mem_rdata is taken in that same cycle) and mem_req drops on the
// following cycle. mem_ack while mem_req is low has no meaning and is ignored.
interface serial_lsu_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 12,
    parameter int DIGIT  = 1
);
    localparam int BE_W = XLEN / 8;
    localparam int MA_W = ADDR_W - $clog2(BE_W);

    logic             start;
    logic             store;
    logic [2:0]       func;
    logic [DIGIT-1:0] ser_in;
    logic [DIGIT-1:0] ser_out;
    logic             ser_valid;
    logic             busy;
    logic             done;
    logic             err;
    logic [MA_W-1:0]  mem_addr;
    logic             mem_req;
    logic             mem_we;
    logic [BE_W-1:0]  mem_be;
    logic [XLEN-1:0]  mem_wdata;
    logic [XLEN-1:0]  mem_rdata;
    logic             mem_ack;

    modport slave (
        input  start, store, func, ser_in, mem_rdata, mem_ack,
        output ser_out, ser_valid, busy, done, err,
               mem_addr, mem_req, mem_we, mem_be, mem_wdata
    );

    modport master (
        output start, store, func, ser_in, mem_rdata, mem_ack,
        input  ser_out, ser_valid, busy, done, err,
               mem_addr, mem_req, mem_we, mem_be, mem_wdata
    );
endinterface

// File: rtl/serial_lsu.sv
// serial_lsu: digit-serial load/store unit between a serial core datapath and
// a parallel word-wide data memory.
//
// A transaction shifts in a byte address (N = XLEN/DIGIT digits, LSB first),
// checks legality/alignment, shifts in store data for stores, performs one
// req/ack memory access with byte-lane steering, and for loads streams the
// sign/zero-extended result back out N digits, LSB first.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   bus          serial_lsu_if.slave (core and memory signals)
//   dbg_state_o  current FSM state encoding (IDLE=0 .. DONE=6)
//
// All outputs are decoded from registered state; none depend combinationally
// on inputs.
module serial_lsu #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 12,
    parameter int DIGIT  = 1
) (
    input  logic               clk,
    input  logic               rst,
    serial_lsu_if.slave        bus,
    output logic [2:0]         dbg_state_o
);
    localparam int N     = XLEN / DIGIT;
    localparam int BE_W  = XLEN / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        CHECK = 3'd2,
        DATA  = 3'd3,
        MEM   = 3'd4,
        OUT   = 3'd5,
        DONE  = 3'd6
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    // One shift register serves three roles in turn: incoming address,
    // incoming store data, and outgoing load result.
    logic [XLEN-1:0]   sh_q, sh_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              store_q, store_d;
    logic [2:0]        func_q, func_d;
    logic              err_q, err_d;

    logic              illegal;
    logic              misaligned;
    logic [OFF_W-1:0]  off;
    logic [BE_W-1:0]   be;
    logic [XLEN-1:0]   wdata;
    logic [XLEN-1:0]   lval;
    logic [XLEN-1:0]   ldext;
    logic              sgn;

    assign off = addr_q[OFF_W-1:0];

    // Legality and alignment, evaluated in CHECK while sh_q still holds the
    // freshly shifted address.
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        if (store_q) begin
            illegal = func_q[2] || ((XLEN == 32) && (func_q[1:0] == 2'b11));
        end else begin
            // 111 is not a load encoding; LD and LWU only exist on RV64.
            illegal = (func_q == 3'b111) ||
                      ((XLEN == 32) && ((func_q == 3'b011) || (func_q == 3'b110)));
        end
        case (func_q[1:0])
            2'b01:   misaligned = sh_q[0];
            2'b10:   misaligned = |sh_q[1:0];
            2'b11:   misaligned = |sh_q[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    // Lane steering: byte enables, replicated store data and extended load
    // value. Accesses reaching MEM are aligned, so shifting the size mask by
    // the byte offset never runs off the top of the word.
    always_comb begin
        case (func_q[1:0])
            2'b00:   be = BE_W'(1) << off;
            2'b01:   be = BE_W'(3) << off;
            2'b10:   be = BE_W'(15) << off;
            default: be = '1;
        endcase

        wdata = sh_q;
        case (func_q[1:0])
            2'b00:   for (int i = 0; i < BE_W; i++)      wdata[i*8 +: 8]   = sh_q[7:0];
            2'b01:   for (int i = 0; i < BE_W / 2; i++)  wdata[i*16 +: 16] = sh_q[15:0];
            2'b10:   for (int i = 0; i < XLEN / 32; i++) wdata[i*32 +: 32] = sh_q[31:0];
            default: wdata = sh_q;
        endcase

        lval  = bus.mem_rdata >> {off, 3'b000};
        ldext = lval;
        sgn   = 1'b0;
        case (func_q[1:0])
            2'b00: begin
                sgn = lval[7] & ~func_q[2];
                for (int i = 8; i < XLEN; i++) ldext[i] = sgn;
            end
            2'b01: begin
                sgn = lval[15] & ~func_q[2];
                for (int i = 16; i < XLEN; i++) ldext[i] = sgn;
            end
            2'b10: begin
                sgn = lval[31] & ~func_q[2];
                for (int i = 32; i < XLEN; i++) ldext[i] = sgn;
            end
            default: ldext = lval;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        addr_d  = addr_q;
        store_d = store_q;
        func_d  = func_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    store_d = bus.store;
                    func_d  = bus.func;
                    err_d   = 1'b0;
                    sh_d    = {bus.ser_in, sh_q[XLEN-1:DIGIT]};
                    cnt_d   = CNT_W'(1);
                    state_d = ADDR;
                end
            end
            ADDR: begin
                sh_d = {bus.ser_in, sh_q[XLEN-1:DIGIT]};
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CHECK: begin
                // Upper address bits beyond ADDR_W are dropped here.
                addr_d = sh_q[ADDR_W-1:0];
                if (illegal || misaligned) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (store_q) begin
                    state_d = DATA;
                end else begin
                    state_d = MEM;
                end
            end
            DATA: begin
                sh_d = {bus.ser_in, sh_q[XLEN-1:DIGIT]};
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = MEM;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            MEM: begin
                if (bus.mem_ack) begin
                    if (!store_q) begin
                        sh_d = ldext;
                    end
                    state_d = store_q ? DONE : OUT;
                end
            end
            OUT: begin
                sh_d = {{DIGIT{1'b0}}, sh_q[XLEN-1:DIGIT]};
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            addr_q  <= '0;
            store_q <= 1'b0;
            func_q  <= 3'b000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            func_q  <= func_d;
            err_q   <= err_d;
        end
    end

    // Outputs are decoded from the state register; memory-side values are
    // forced to zero outside MEM so the bus is quiet when no request is up.
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.err       = (state_q == DONE) && err_q;
    assign bus.mem_req   = (state_q == MEM);
    assign bus.mem_we    = (state_q == MEM) && store_q;
    assign bus.mem_be    = (state_q == MEM) ? be : '0;
    assign bus.mem_wdata = ((state_q == MEM) && store_q) ? wdata : '0;
    assign bus.mem_addr  = (state_q == MEM) ? addr_q[ADDR_W-1:OFF_W] : '0;
    assign bus.ser_valid = (state_q == OUT);
    assign bus.ser_out   = (state_q == OUT) ? sh_q[DIGIT-1:0] : '0;
    assign dbg_state_o   = state_q;
endmodule

// File: doc/serial_lsu.md
# serial_lsu

- Parametrised bit/digit-serial load/store unit.
- Sits between the serial core datapath and the parallel word-wide data memory.
- Shifts in a byte address and, for stores, the store data, DIGIT bits per cycle, LSB first. For loads it streams the extended result back out the same way.
- Handles byte/halfword/word (and doubleword when XLEN=64) accesses, byte-lane steering, sign/zero extension, misalignment and illegal-func detection, and a req/ack memory handshake.

## Interface
- XLEN, 32: datapath width; 32 or 64.
- ADDR_W, 12: byte-address bits retained; upper shifted-in address bits are discarded.
- DIGIT, 1: bits per serial cycle; 1, 2, 4 or 8. N = XLEN/DIGIT cycles per operand.
- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  begin transaction; sampled in IDLE only.
- store  in  1  1 = store, 0 = load; sampled with start.
- func  in  3  RISC-V funct3; sampled with start.
- ser_in  in  DIGIT  serial address/store-data digit.
- ser_out  out  DIGIT  serial load-result digit.
- ser_valid  out  1  ser_out is valid.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  misaligned or illegal access; valid only with done.
- mem_addr  out  ADDR_W-log2(XLEN/8)  word address.
- mem_req  out  1  memory request.
- mem_we  out  1  write enable; qualified by mem_req.
- mem_be  out  XLEN/8  byte enables.
- mem_wdata  out  XLEN  lane-replicated store data.
- mem_rdata  in  XLEN  read data; sampled on mem_ack.
- mem_ack  in  1  memory acknowledge.

## Operation
- States: IDLE, ADDR, CHECK, DATA, MEM, OUT, DONE.
- **IDLE**
  - On start, latch store and func and shift address digit 0 from ser_in.
  - Go to ADDR.
- **ADDR**
  - Shift address digits 1..N-1, one per cycle.
  - Go to CHECK after the last digit.
- **CHECK** (one cycle)
  - Evaluate legality and alignment.
  - Illegal func:
    - load: 011 when XLEN=32; 110 when XLEN=32.
    - store: func[2]=1; 011 when XLEN=32.
  - Misaligned:
    - halfword with addr[0]=1.
    - word with addr[1:0]≠0.
    - doubleword with addr[2:0]≠0.
  - On error go to DONE with err=1; no memory access occurs.
  - Otherwise go to DATA (store) or MEM (load).
- **DATA** (store only)
  - Shift N store digits.
  - Go to MEM.
- **MEM**
  - mem_req=1; mem_we=store.
  - mem_be is a one-hot or contiguous lane set selected by size and addr low bits.
  - mem_wdata holds the byte/halfword/word replicated across all lanes.
  - Stay in MEM until mem_ack.
  - Load: capture mem_rdata on the ack cycle, then go to OUT.
  - Store: go to DONE on ack.
- **OUT** (load only)
  - Emit N digits of the lane-selected value, LSB first, with ser_valid=1.
  - Digits above the access size carry the sign bit (func[2]=0) or 0 (func[2]=1, unsigned).
  - Go to DONE.
- **DONE** (one cycle)
  - done=1; err as decided in CHECK.
  - Go to IDLE.
- Ignored inputs:
  - start while busy.
  - mem_ack outside MEM.
  - ser_in outside IDLE-with-start, ADDR and DATA.

## Timing
- All outputs are registered or decoded from the state register; nothing is combinational from inputs.
- Reset values:
  - state=IDLE.
  - busy, done, err, mem_req, mem_we, ser_valid = 0.
  - mem_be, mem_wdata, mem_addr, ser_out = 0.
- Load, ack in first MEM cycle (cycle 0 = start cycle):
  - ADDR: cycles 1..N-1.
  - CHECK: cycle N.
  - MEM: cycle N+1.
  - OUT: cycles N+2..2N+1.
  - done: cycle 2N+2.
- Store, ack in first MEM cycle:
  - DATA: cycles N+1..2N.
  - MEM: cycle 2N+1.
  - done: cycle 2N+2.
- Each cycle mem_ack is withheld adds one cycle.
- Error path: done/err at cycle N+1.
- mem_req rises the first MEM cycle and falls the cycle after ack. Address, we, be and wdata stay stable while mem_req=1.
- rst mid-transaction returns to IDLE at that edge.
  - mem_req, ser_valid and done are 0 the next cycle.
  - A late ack is ignored.
- start is accepted in the same cycle as DONE's successor (IDLE); back-to-back spacing is 2N+3 cycles minimum.

## Test plan
- XLEN=32, DIGIT=1, LW addr 0x104, rdata 0xDEADBEEF, ack cycle 33 -> mem_addr=0x41, be=1111, ser_out streams 0xDEADBEEF cycles 34-65, done cycle 66, err=0.
- LB addr 0x007, rdata 0x80FF_0000 -> be=1000, result 0xFFFFFF80; LBU same -> 0x00000080.
- SH addr 0x002, data 0x0000ABCD, DIGIT=4 -> mem_we=1, be=1100, wdata=0xABCDABCD, done cycle 18.
- LW addr 0x006 -> err=1 with done at cycle N+1, mem_req never asserted; func=011 when XLEN=32 -> err=1.
- mem_ack held low 5 extra MEM cycles -> mem_req high 6 cycles, outputs stable, done delayed by 5.
- rst asserted during OUT, and start pulsed while busy -> next cycle state IDLE, all outputs 0; busy-time start has no effect.
